oflow_core_set_dispatcher: RTL and testbench

Parametrised frame-to-set scheduler for the oflow core. It splits a frame of num_of_bbox_in_frame bboxes into ceil(N/PE_NUM) sets and handshakes each set in from the DMA. It fires feature extraction only on the PEs that hold valid bboxes, collects per-PE done in any order, and hands each completed set to the registration stage through a ready/valid handshake. The DMA may load set k+1 while the registration stage still owns set k.

---
 rtl/oflow_dispatch_pkg.sv | 31 +++
 rtl/oflow_set_handoff_slot.sv | 34 +++
 rtl/oflow_core_set_dispatcher.sv | 144 ++++++++++++++
 tb/tb_oflow_core_set_dispatcher.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/oflow_dispatch_pkg.sv
// Shared types and defaults for the oflow frame-to-set dispatcher.
// The optional watchdog is enabled with OFLOW_DISPATCH_TIMEOUT_EN.
package oflow_dispatch_pkg;

    localparam int PE_NUM_DEF     = 24;
    localparam int MAX_BBOXES_DEF = 256;
    localparam int CNT_W_DEF      = $clog2(MAX_BBOXES_DEF + 1);
    localparam int SET_W_DEF      = $clog2((MAX_BBOXES_DEF + PE_NUM_DEF - 1) / PE_NUM_DEF + 1);
    localparam int MAX_PE         = 64;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_SET = 3'd1,
        FE_START = 3'd2,
        FE_RUN   = 3'd3,
        HANDOFF  = 3'd4,
        FINISH   = 3'd5
    } state_t;

    // Lanes holding a valid bbox: all pe_num lanes, or the low 'remain' lanes of a short set.
    function automatic logic [MAX_PE-1:0] mask_from_remain(input int unsigned remain,
                                                           input int unsigned pe_num);
        logic [MAX_PE-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_PE; i++) begin
            if (i < pe_num && i < remain) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/oflow_set_handoff_slot.sv
// Single-entry valid/ready register holding the completed set for registration.
// Payload is stable while valid is high; a load takes priority over a same-cycle consume.
module oflow_set_handoff_slot
    import oflow_dispatch_pkg::*;
#(
    parameter int PE_NUM = PE_NUM_DEF,
    parameter int SET_W  = SET_W_DEF
) (
    input  logic              clk,
    input  logic              reset_N,
    input  logic              load,
    input  logic [SET_W-1:0]  load_idx,
    input  logic [PE_NUM-1:0] load_mask,
    input  logic              ready,
    output logic              valid,
    output logic [SET_W-1:0]  idx,
    output logic [PE_NUM-1:0] mask
);

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            valid <= 1'b0;
            idx   <= '0;
            mask  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            idx   <= load_idx;
            mask  <= load_mask;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/oflow_core_set_dispatcher.sv
// Splits a frame into PE_NUM-wide sets, runs FE on the valid lanes and hands each set to registration.
// Optional per-set watchdog: define OFLOW_DISPATCH_TIMEOUT_EN.
module oflow_core_set_dispatcher
    import oflow_dispatch_pkg::*;
#(
    parameter int PE_NUM         = PE_NUM_DEF,
    parameter int MAX_BBOXES     = MAX_BBOXES_DEF,
    parameter int CNT_W          = $clog2(MAX_BBOXES + 1),
    parameter int SET_W          = $clog2((MAX_BBOXES + PE_NUM - 1) / PE_NUM + 1),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_N,
    input  logic              start_frame,
    input  logic [CNT_W-1:0]  num_of_bbox_in_frame,
    input  logic              new_set_from_dma,
    output logic              ready_new_set,
    output logic [PE_NUM-1:0] start_fe_i,
    input  logic [PE_NUM-1:0] done_fe_i,
    output logic [PE_NUM-1:0] active_mask,
    output logic [SET_W-1:0]  counter_set_fe,
    output logic              set_valid_to_reg,
    input  logic              reg_ready,
    output logic [SET_W-1:0]  set_idx_to_reg,
    output logic [PE_NUM-1:0] mask_to_reg,
    output logic              done_frame,
    output logic              busy,
    output logic              fe_timeout,
    output logic [2:0]        dbg_state
);

    // Handshakes: a transfer happens on any cycle where valid and ready are both 1 at the clock edge
    // (new_set_from_dma/ready_new_set and set_valid_to_reg/reg_ready); valid payload holds until then.

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  n_sat, remain;
    logic [SET_W-1:0]  num_sets, num_sets_d;
    logic [PE_NUM-1:0] mask_reg, mask_nxt, done_acc, load_mask;
    logic              covered, to_hit, timed_q, slot_free, slot_load, last_set, done_frame_q;

    assign n_sat      = (num_of_bbox_in_frame > CNT_W'(MAX_BBOXES)) ? CNT_W'(MAX_BBOXES)
                                                                     : num_of_bbox_in_frame;
    assign num_sets_d = SET_W'((32'(n_sat) + PE_NUM - 1) / PE_NUM);
    assign mask_nxt   = PE_NUM'(mask_from_remain(32'(remain), PE_NUM));
    assign covered    = (state == FE_RUN) && (((done_acc | done_fe_i) & mask_reg) == mask_reg);
    assign slot_free  = !set_valid_to_reg || reg_ready;
    assign last_set   = (SET_W'(counter_set_fe + 1'b1) == num_sets);
    assign load_mask  = timed_q ? done_acc : mask_reg;

`ifdef OFLOW_DISPATCH_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            to_cnt  <= '0;
            timed_q <= 1'b0;
        end else if (state == FE_START) begin
            to_cnt  <= '0;
            timed_q <= 1'b0;
        end else if (state == FE_RUN) begin
            to_cnt  <= to_cnt + 1'b1;
            timed_q <= fe_timeout;
        end
    end

    assign to_hit = (state == FE_RUN) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign to_hit  = 1'b0 & (TIMEOUT_CYCLES == 0);
    assign timed_q = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_frame) state_nxt = (n_sat == '0) ? FINISH : WAIT_SET;
            WAIT_SET: if (new_set_from_dma) state_nxt = FE_START;
            FE_START: state_nxt = FE_RUN;
            FE_RUN:   if (covered || to_hit) state_nxt = HANDOFF;
            HANDOFF:  if (slot_free) state_nxt = last_set ? FINISH : WAIT_SET;
            FINISH:   if (!set_valid_to_reg) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_new_set = (state == WAIT_SET);
        start_fe_i    = (state == FE_START) ? mask_reg : '0;
        busy          = (state != IDLE);
        fe_timeout    = to_hit && !covered;
        slot_load     = (state == HANDOFF) && slot_free;
        dbg_state     = state;
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            num_sets       <= '0;
            remain         <= '0;
            counter_set_fe <= '0;
            mask_reg       <= '0;
            done_acc       <= '0;
            done_frame_q   <= 1'b0;
        end else begin
            done_frame_q <= (state == FINISH) && !set_valid_to_reg;
            if (state == IDLE && start_frame) begin
                num_sets       <= num_sets_d;
                remain         <= n_sat;
                counter_set_fe <= '0;
            end
            if (state == WAIT_SET && new_set_from_dma) mask_reg <= mask_nxt;
            // Dones seen during FE_START belong to no set and are dropped with the clear.
            if (state == FE_START)    done_acc <= '0;
            else if (state == FE_RUN) done_acc <= done_acc | (done_fe_i & mask_reg);
            if (slot_load) begin
                remain         <= remain - CNT_W'($countones(mask_reg));
                counter_set_fe <= counter_set_fe + 1'b1;
            end
        end
    end

    assign active_mask = mask_reg;
    assign done_frame  = done_frame_q;

    oflow_set_handoff_slot #(
        .PE_NUM (PE_NUM),
        .SET_W  (SET_W)
    ) u_slot (
        .clk       (clk),
        .reset_N   (reset_N),
        .load      (slot_load),
        .load_idx  (counter_set_fe),
        .load_mask (load_mask),
        .ready     (reg_ready),
        .valid     (set_valid_to_reg),
        .idx       (set_idx_to_reg),
        .mask      (mask_to_reg)
    );

endmodule

// File: tb/tb_oflow_core_set_dispatcher.sv
// Directed bench for oflow_core_set_dispatcher: vector table of frames plus stall, reset and N=0 sequences.
// The watchdog sequence is compiled in when OFLOW_DISPATCH_TIMEOUT_EN is defined.
module tb_oflow_core_set_dispatcher;

    localparam int          PE   = 24;
    localparam int          SW   = 4;
    localparam int          CW   = 9;
    localparam logic [23:0] FULL = 24'hFFFFFF;

    logic          clk = 1'b0;
    logic          reset_N;
    logic          start_frame;
    logic [CW-1:0] num_of_bbox_in_frame;
    logic          new_set_from_dma;
    logic          ready_new_set;
    logic [PE-1:0] start_fe_i, done_fe_i, active_mask, mask_to_reg;
    logic [SW-1:0] counter_set_fe, set_idx_to_reg;
    logic          set_valid_to_reg, reg_ready, done_frame, busy, fe_timeout;
    logic [2:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    int start_fe_cnt = 0, rdy_cnt = 0, done_cnt = 0, to_pulses = 0;
    logic [SW+PE-1:0] exp_q[$];

    typedef struct {
        int          n;
        int          sets;
        logic [23:0] last;
        int          mode;
        bit          inact;
    } vec_t;
    vec_t vecs[6];

    oflow_core_set_dispatcher #(.PE_NUM(PE), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_N(reset_N), .start_frame(start_frame),
        .num_of_bbox_in_frame(num_of_bbox_in_frame), .new_set_from_dma(new_set_from_dma),
        .ready_new_set(ready_new_set), .start_fe_i(start_fe_i), .done_fe_i(done_fe_i),
        .active_mask(active_mask), .counter_set_fe(counter_set_fe),
        .set_valid_to_reg(set_valid_to_reg), .reg_ready(reg_ready),
        .set_idx_to_reg(set_idx_to_reg), .mask_to_reg(mask_to_reg), .done_frame(done_frame),
        .busy(busy), .fe_timeout(fe_timeout), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every consumed handoff must match the next expected {idx, mask}.
    always @(negedge clk) begin
        if (reset_N) begin
            if (|start_fe_i) start_fe_cnt++;
            if (ready_new_set) rdy_cnt++;
            if (done_frame) done_cnt++;
            if (fe_timeout) to_pulses++;
            if (set_valid_to_reg && reg_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL handoff_extra actual=%0h expected=none", {set_idx_to_reg, mask_to_reg});
                end else begin
                    check("handoff", {set_idx_to_reg, mask_to_reg}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic check_reset_outs(input string name);
        check(name, {ready_new_set, start_fe_i, active_mask, counter_set_fe, set_valid_to_reg,
                     set_idx_to_reg, mask_to_reg, done_frame, busy, fe_timeout, dbg_state}, '0);
    endtask

    task automatic begin_frame(input int n);
        num_of_bbox_in_frame = CW'(n);
        start_frame = 1'b1;
        tick();
        start_frame = 1'b0;
    endtask

    // mode 0: all dones together; mode 1: done pulsed in FE_START, then reverse lane order.
    task automatic do_set(input int k, input logic [23:0] m, input int mode, input bit inact,
                          input bit chk_lat);
        int w = 0;
        while (!ready_new_set && w < 100) begin tick(); w++; end
        check("wait_ready", ready_new_set, 1);
        if (!ready_new_set) return;
        exp_q.push_back({SW'(k), m});
        new_set_from_dma = 1'b1;
        tick();
        new_set_from_dma = 1'b0;
        check("start_fe", start_fe_i, m);
        check("active_mask", active_mask, m);
        check("counter_set", counter_set_fe, k);
        if (mode == 1) done_fe_i = m;
        tick();
        done_fe_i = '0;
        if (mode == 0) begin
            done_fe_i = m;
            tick();
            done_fe_i = '0;
        end else begin
            if (inact) begin done_fe_i = ~m; tick(); end
            for (int l = PE - 1; l >= 1; l--) begin
                if (m[l]) begin done_fe_i = 24'(1) << l; tick(); end
            end
            done_fe_i = '0;
            check("fe_run_hold", dbg_state, 3);
            done_fe_i = 24'h1;
            tick();
            done_fe_i = '0;
        end
        tick();
        if (chk_lat) begin
            check("lat_valid", set_valid_to_reg, 1);
            check("lat_idx", set_idx_to_reg, k);
            check("lat_mask", mask_to_reg, m);
        end
    endtask

    task automatic wait_done();
        int w = 0;
        while (!done_frame && w < 400) begin tick(); w++; end
        check("done_frame", done_frame, 1);
    endtask

    task automatic run_frame(input vec_t v);
        int sf0 = start_fe_cnt;
        int df0 = done_cnt;
        begin_frame(v.n);
        check("busy_set", busy, 1);
        for (int k = 0; k < v.sets; k++)
            do_set(k, (k == v.sets - 1) ? v.last : FULL, v.mode, v.inact, 1'b1);
        wait_done();
        check("busy_low", busy, 0);
        tick();
        check("done_pulses", done_cnt - df0, 1);
        check("fe_sets", start_fe_cnt - sf0, v.sets);
        check("q_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int sf0, rd0, df0;
        bit stall_ok;
        vecs[0] = '{n: 50,  sets: 3,  last: 24'h000003, mode: 0, inact: 1'b0};
        vecs[1] = '{n: 48,  sets: 2,  last: 24'hFFFFFF, mode: 1, inact: 1'b0};
        vecs[2] = '{n: 5,   sets: 1,  last: 24'h00001F, mode: 1, inact: 1'b1};
        vecs[3] = '{n: 24,  sets: 1,  last: 24'hFFFFFF, mode: 0, inact: 1'b0};
        vecs[4] = '{n: 300, sets: 11, last: 24'h00FFFF, mode: 0, inact: 1'b0};
        vecs[5] = '{n: 1,   sets: 1,  last: 24'h000001, mode: 1, inact: 1'b1};

        reset_N = 1'b0;
        start_frame = 1'b0;
        num_of_bbox_in_frame = '0;
        new_set_from_dma = 1'b0;
        done_fe_i = '0;
        reg_ready = 1'b1;
        repeat (3) tick();
        check_reset_outs("reset_state");
        reset_N = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        // Empty frame goes straight to FINISH.
        sf0 = start_fe_cnt; rd0 = rdy_cnt; df0 = done_cnt;
        begin_frame(0);
        check("n0_busy", busy, 1);
        check("n0_done_early", done_frame, 0);
        tick();
        check("n0_done", done_frame, 1);
        check("n0_busy_low", busy, 0);
        tick();
        check("n0_no_fe", start_fe_cnt - sf0, 0);
        check("n0_no_ready", rdy_cnt - rd0, 0);
        check("n0_done_cnt", done_cnt - df0, 1);

        // Registration stalls: set 0 sits in the slot while set 1 finishes FE.
        reg_ready = 1'b0;
        begin_frame(72);
        do_set(0, FULL, 0, 1'b0, 1'b1);
        do_set(1, FULL, 0, 1'b0, 1'b0);
        stall_ok = 1'b1;
        for (int c = 0; c < 28; c++) begin
            if (dbg_state != 3'd4 || ready_new_set || !set_valid_to_reg || set_idx_to_reg != 0)
                stall_ok = 1'b0;
            tick();
        end
        check("stall_hold", stall_ok, 1);
        reg_ready = 1'b1;
        do_set(2, FULL, 0, 1'b0, 1'b0);
        wait_done();
        tick();
        check("stall_q_empty", exp_q.size(), 0);

        // Asynchronous reset while set 1 is in FE_RUN.
        begin_frame(48);
        do_set(0, FULL, 0, 1'b0, 1'b1);
        check("rst_ready", ready_new_set, 1);
        new_set_from_dma = 1'b1;
        tick();
        new_set_from_dma = 1'b0;
        tick();
        tick();
        check("rst_in_fe_run", dbg_state, 3);
        reset_N = 1'b0;
        #1;
        check_reset_outs("async_reset");
        df0 = done_cnt;
        repeat (3) tick();
        reset_N = 1'b1;
        tick();
        check("rst_no_done", done_cnt - df0, 0);
        check("rst_q_empty", exp_q.size(), 0);
        run_frame(vecs[3]);

`ifdef OFLOW_DISPATCH_TIMEOUT_EN
        begin
            int c;
            begin_frame(24);
            check("to_ready", ready_new_set, 1);
            exp_q.push_back({SW'(0), 24'hFFFF7F});
            new_set_from_dma = 1'b1;
            tick();
            new_set_from_dma = 1'b0;
            tick();
            done_fe_i = 24'hFFFF7F;
            tick();
            done_fe_i = '0;
            c = 2;
            while (c < 40 && !fe_timeout) begin tick(); c++; end
            check("to_cycle", c, 16);
            tick();
            tick();
            check("to_mask", mask_to_reg, 24'hFFFF7F);
            wait_done();
            tick();
            check("to_pulses", to_pulses, 1);
        end
`else
        check("no_timeout", to_pulses, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
